// File: rtl/tuman_gen_data.sv
// Stimulus/monitor for the packet-processing user module: streams a firmware-load
// packet and synthetic test packets on packet-in, and counts/format-checks packet-out.
module tuman_gen_data #(
    parameter int          MEM_DEPTH   = 1024,
    parameter int          FW_WORDS    = 256,
    parameter logic [15:0] FW_TAG      = 16'h9005,
    parameter int          START_DELAY = 16,
    parameter int          GAP         = 32,
    parameter int          NUM_PKTS    = 4,
    parameter int          PKT_BEATS   = 4
) (
    input  logic         clk,
    input  logic         resetn,
    output logic         data_in_valid,
    output logic [133:0] data_in,
    input  logic         data_out_valid,
    input  logic [133:0] data_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_FW_HDR  = 3'd2;
    localparam logic [2:0] S_FW_DATA = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_PKT     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [1:0] FLAG_FIRST = 2'b01;
    localparam logic [1:0] FLAG_MID   = 2'b11;
    localparam logic [1:0] FLAG_LAST  = 2'b10;

    localparam int          AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] WAIT_LAST  = 32'(START_DELAY - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP - 1);
    localparam logic [31:0] FW_LAST    = 32'(FW_WORDS / 4 - 1);
    localparam logic [31:0] BEAT_LAST  = 32'(PKT_BEATS - 1);
    localparam logic [31:0] PKT_TOTAL  = 32'(NUM_PKTS);
    localparam logic [63:0] PKT_FILL   = 64'hA5A5_A5A5_A5A5_A5A5;

    // Firmware image; loaded from outside the design before reset is released.
    logic [31:0] memory [0:MEM_DEPTH-1];

    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_fwBeat;
    logic [31:0] r_pktIdx;
    logic [31:0] r_beatIdx;
    logic        r_rxOpen;

    logic [31:0] rx_pkt_cnt;
    logic [31:0] rx_beat_cnt;
    logic        rx_err;
    logic        done;

    logic [AW-1:0]  w_addr;
    logic [127:0]   w_fwPayload;
    logic [1:0]     w_fwFlags;
    logic [1:0]     w_pktFlags;
    logic [1:0]     w_rxFlags;
    logic           w_unusedPayload;

    assign w_addr      = AW'({r_fwBeat[29:0], 2'b00});
    assign w_fwPayload = {memory[w_addr], memory[w_addr + AW'(1)],
                          memory[w_addr + AW'(2)], memory[w_addr + AW'(3)]};
    assign w_fwFlags   = (r_fwBeat == FW_LAST) ? FLAG_LAST : FLAG_MID;
    assign w_pktFlags  = (r_beatIdx == 32'd0)     ? FLAG_FIRST :
                         (r_beatIdx == BEAT_LAST) ? FLAG_LAST  : FLAG_MID;
    assign w_rxFlags   = data_out[133:132];
    assign w_unusedPayload = ^data_out[131:0];

    // Each state decides the beat registered on this edge, so a beat follows its state by one cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_fwBeat      <= '0;
            r_pktIdx      <= '0;
            r_beatIdx     <= '0;
            data_in_valid <= 1'b0;
            data_in       <= '0;
            done          <= 1'b0;
        end else begin
            data_in_valid <= 1'b0;
            data_in       <= '0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_cnt == WAIT_LAST) begin
                        r_state <= S_FW_HDR;
                    end
                end
                S_FW_HDR: begin
                    data_in_valid <= 1'b1;
                    data_in       <= {FLAG_FIRST, 4'h0, FW_TAG, 16'(FW_WORDS), 96'b0};
                    r_fwBeat      <= '0;
                    r_state       <= S_FW_DATA;
                end
                S_FW_DATA: begin
                    data_in_valid <= 1'b1;
                    data_in       <= {w_fwFlags, 4'h0, w_fwPayload};
                    if (r_fwBeat == FW_LAST) begin
                        r_state  <= S_GAP;
                        r_cnt    <= '0;
                        r_pktIdx <= '0;
                    end else begin
                        r_fwBeat <= r_fwBeat + 32'd1;
                    end
                end
                S_GAP: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_cnt == GAP_LAST) begin
                        r_beatIdx <= '0;
                        r_state   <= (r_pktIdx == PKT_TOTAL) ? S_DONE : S_PKT;
                    end
                end
                S_PKT: begin
                    data_in_valid <= 1'b1;
                    data_in       <= {w_pktFlags, 4'h0, r_pktIdx, r_beatIdx, PKT_FILL};
                    if (r_beatIdx == BEAT_LAST) begin
                        r_state  <= S_GAP;
                        r_cnt    <= '0;
                        r_pktIdx <= r_pktIdx + 32'd1;
                    end else begin
                        r_beatIdx <= r_beatIdx + 32'd1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Packet-out monitor: a 01 on an open packet is an error but still starts the new packet.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_pkt_cnt  <= '0;
            rx_beat_cnt <= '0;
            rx_err      <= 1'b0;
            r_rxOpen    <= 1'b0;
        end else if (data_out_valid) begin
            rx_beat_cnt <= rx_beat_cnt + 32'd1;
            case (w_rxFlags)
                FLAG_FIRST: begin
                    if (r_rxOpen) begin
                        rx_err <= 1'b1;
                    end
                    r_rxOpen <= 1'b1;
                end
                FLAG_MID: begin
                    if (!r_rxOpen) begin
                        rx_err <= 1'b1;
                    end
                end
                FLAG_LAST: begin
                    if (r_rxOpen) begin
                        rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
                        r_rxOpen   <= 1'b0;
                    end else begin
                        rx_err <= 1'b1;
                    end
                end
                default: begin
                    rx_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuman_gen_data.sv
// Directed bench for tuman_gen_data at default parameters: reset, firmware packet,
// test packets, loopback RX counts, RX error detection and mid-packet reset.
module tb_tuman_gen_data;

    logic         clk = 1'b0;
    logic         resetn;
    logic         dataInValid;
    logic [133:0] dataIn;
    logic         dataOutValid;
    logic [133:0] dataOut;
    logic         loopback;
    logic         tbValid;
    logic [133:0] tbBeat;

    int total = 0;
    int bad   = 0;

    assign dataOutValid = loopback ? dataInValid : tbValid;
    assign dataOut      = loopback ? dataIn      : tbBeat;

    tuman_gen_data dut (
        .clk            (clk),
        .resetn         (resetn),
        .data_in_valid  (dataInValid),
        .data_in        (dataIn),
        .data_out_valid (dataOutValid),
        .data_out       (dataOut)
    );

    always #5 clk = ~clk;

    localparam logic [133:0] HDR_BEAT = {2'b01, 4'h0, 16'h9005, 16'd256, 96'b0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [133:0] observed,
                               input logic [133:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one beat on packet-out with the given position flags.
    task automatic applyStimulus(input logic [1:0] flags);
        tbValid = 1'b1;
        tbBeat  = {flags, 4'h0, 128'h0};
        tick;
        tbValid = 1'b0;
        tbBeat  = '0;
    endtask

    // Counts idle cycles until the next valid beat, giving up after bound cycles.
    task automatic waitValid(input int bound, output int idle);
        idle = 0;
        tick;
        while (!dataInValid && idle < bound) begin
            idle++;
            tick;
        end
    endtask

    function automatic logic [133:0] fwExpect(input int b);
        logic [1:0] flags;
        flags = (b == 63) ? 2'b10 : 2'b11;
        return {flags, 4'h0, 32'(4*b), 32'(4*b+1), 32'(4*b+2), 32'(4*b+3)};
    endfunction

    function automatic logic [133:0] pktExpect(input int i, input int j);
        logic [1:0] flags;
        flags = (j == 0) ? 2'b01 : ((j == 3) ? 2'b10 : 2'b11);
        return {flags, 4'h0, 32'(i), 32'(j), 64'hA5A5_A5A5_A5A5_A5A5};
    endfunction

    initial begin
        int idle;
        int fwCount;

        for (int i = 0; i < 1024; i++) begin
            dut.memory[i] = 32'(i);
        end
        resetn   = 1'b0;
        loopback = 1'b1;
        tbValid  = 1'b0;
        tbBeat   = '0;

        // Reset held for 100 cycles
        for (int c = 0; c < 100; c++) tick;
        checkOutput("rst_valid", 134'(dataInValid), 134'(0));
        checkOutput("rst_data", dataIn, 134'(0));
        checkOutput("rst_pkt_cnt", 134'(dut.rx_pkt_cnt), 134'(0));
        checkOutput("rst_beat_cnt", 134'(dut.rx_beat_cnt), 134'(0));
        checkOutput("rst_err", 134'(dut.rx_err), 134'(0));
        checkOutput("rst_done", 134'(dut.done), 134'(0));

        // Firmware header after start delay
        resetn = 1'b1;
        waitValid(100, idle);
        checkOutput("start_latency", 134'(idle), 134'(17));
        checkOutput("fw_hdr", dataIn, HDR_BEAT);

        // Firmware data beats
        fwCount = 0;
        for (int k = 1; k <= 64; k++) begin
            tick;
            if (dataInValid) fwCount++;
            if (k == 1 || k == 10 || k == 64)
                checkOutput($sformatf("fw_beat%0d", k), dataIn, fwExpect(k - 1));
        end
        checkOutput("fw_data_beats", 134'(fwCount), 134'(64));
        waitValid(200, idle);
        checkOutput("gap_after_fw", 134'(idle), 134'(32));

        // Test packets
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j > 0) tick;
                checkOutput($sformatf("pkt%0d_beat%0d", i, j), dataIn, pktExpect(i, j));
            end
            if (i < 3) begin
                waitValid(200, idle);
                checkOutput($sformatf("gap_before_pkt%0d", i + 1), 134'(idle), 134'(32));
            end
        end

        // Final gap then done
        for (int c = 0; c < 32; c++) tick;
        checkOutput("final_gap_valid", 134'(dataInValid), 134'(0));
        checkOutput("done_before", 134'(dut.done), 134'(0));
        tick;
        checkOutput("done_after", 134'(dut.done), 134'(1));
        checkOutput("loop_pkt_cnt", 134'(dut.rx_pkt_cnt), 134'(5));
        checkOutput("loop_beat_cnt", 134'(dut.rx_beat_cnt), 134'(81));
        checkOutput("loop_err", 134'(dut.rx_err), 134'(0));
        for (int c = 0; c < 5; c++) tick;
        checkOutput("done_quiet", 134'(dataInValid), 134'(0));
        checkOutput("done_hold", 134'(dut.done), 134'(1));

        // RX error: middle beat while idle, then stickiness
        loopback = 1'b0;
        applyStimulus(2'b11);
        checkOutput("err_mid_idle", 134'(dut.rx_err), 134'(1));
        applyStimulus(2'b01);
        applyStimulus(2'b10);
        checkOutput("err_pkt_cnt", 134'(dut.rx_pkt_cnt), 134'(6));
        checkOutput("err_beat_cnt", 134'(dut.rx_beat_cnt), 134'(84));
        for (int c = 0; c < 5; c++) tick;
        checkOutput("err_sticky", 134'(dut.rx_err), 134'(1));
        resetn = 1'b0;
        tick;
        checkOutput("err_cleared", 134'(dut.rx_err), 134'(0));
        checkOutput("err_beat_cleared", 134'(dut.rx_beat_cnt), 134'(0));

        // RX error: first beat on an already open packet
        resetn = 1'b1;
        applyStimulus(2'b01);
        checkOutput("err_first_ok", 134'(dut.rx_err), 134'(0));
        applyStimulus(2'b01);
        checkOutput("err_double_first", 134'(dut.rx_err), 134'(1));

        // Mid-packet reset during the 10th firmware beat
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        waitValid(100, idle);
        checkOutput("restart_latency", 134'(idle), 134'(17));
        checkOutput("restart_hdr", dataIn, HDR_BEAT);
        for (int k = 1; k <= 9; k++) tick;
        checkOutput("mid_beat_valid", 134'(dataInValid), 134'(1));
        checkOutput("mid_beat_data", dataIn, fwExpect(8));
        resetn = 1'b0;
        tick;
        checkOutput("mid_rst_valid", 134'(dataInValid), 134'(0));
        checkOutput("mid_rst_data", dataIn, 134'(0));
        tick;
        resetn = 1'b1;
        waitValid(100, idle);
        checkOutput("resume_latency", 134'(idle), 134'(17));
        checkOutput("resume_hdr", dataIn, HDR_BEAT);
        tick;
        checkOutput("resume_beat1", dataIn, fwExpect(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
